// File: rtl/ppu_fetch_arbiter_if.sv
// Fetch-arbiter bus: BG fetcher, sprite fetcher and VRAM read port.
// The arbiter uses the slave modport; the fetchers/VRAM side uses master.
// Optional FETCH_ARB_STATS_EN adds the BG stall counter and its clear.
interface ppu_fetch_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              bg_req_in;
  logic [ADDR_W-1:0] bg_addr_in;
  logic              bg_grant_out;
  logic              bg_pause_out;
  logic [DATA_W-1:0] bg_data_out;
  logic              bg_data_valid_out;
  logic              spr_claim_in;
  logic              spr_req_in;
  logic [ADDR_W-1:0] spr_addr_in;
  logic              spr_grant_out;
  logic              mem_free_out;
  logic [DATA_W-1:0] spr_data_out;
  logic              spr_data_valid_out;
  logic [ADDR_W-1:0] vram_addr_out;
  logic              vram_re_out;
  logic [DATA_W-1:0] vram_data_in;
`ifdef FETCH_ARB_STATS_EN
  logic              stats_clr_in;
  logic [15:0]       bg_stall_cycles_out;
`endif

  modport slave (
    input  bg_req_in, bg_addr_in, spr_claim_in, spr_req_in, spr_addr_in, vram_data_in,
`ifdef FETCH_ARB_STATS_EN
    input  stats_clr_in,
    output bg_stall_cycles_out,
`endif
    output bg_grant_out, bg_pause_out, bg_data_out, bg_data_valid_out,
    output spr_grant_out, mem_free_out, spr_data_out, spr_data_valid_out,
    output vram_addr_out, vram_re_out
  );

  modport master (
    output bg_req_in, bg_addr_in, spr_claim_in, spr_req_in, spr_addr_in, vram_data_in,
`ifdef FETCH_ARB_STATS_EN
    output stats_clr_in,
    input  bg_stall_cycles_out,
`endif
    input  bg_grant_out, bg_pause_out, bg_data_out, bg_data_valid_out,
    input  spr_grant_out, mem_free_out, spr_data_out, spr_data_valid_out,
    input  vram_addr_out, vram_re_out
  );
endinterface

// File: rtl/ppu_fetch_arbiter.sv
// Arbitrates the single VRAM read port between the BG and sprite fetchers.
// BG owns the port by default; a sprite claim pauses BG, drains in-flight
// BG reads, then hands the port over until the claim is released.
// Every read carries an owner tag so returning data reaches its requester.
// Optional feature macro: FETCH_ARB_STATS_EN (BG stall cycle counter).
module ppu_fetch_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input logic                clk_in,
  input logic                rst_in,
  ppu_fetch_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {BG_OWN, DRAIN, SPR_OWN} state_t;

  state_t              state, state_nxt;
  logic                bg_grant_c, spr_grant_c;
  logic                re_q, tag_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LATENCY-1:0]  slot_vld, slot_tag;
  logic [CNT_W-1:0]    inflight;
  logic                pause_q, free_q;
  logic                bg_vld_q, spr_vld_q;
  logic [DATA_W-1:0]   bg_data_q, spr_data_q;

  // Reads outstanding: issue stage plus every valid return slot.
  always_comb begin
    inflight = CNT_W'(re_q);
    for (int i = 0; i < int'(LATENCY); i++) begin
      inflight = inflight + CNT_W'(slot_vld[i]);
    end
  end

  // State register with registered pause/mem_free derived from the next state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= BG_OWN;
      pause_q <= 1'b0;
      free_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pause_q <= (state_nxt != BG_OWN);
      free_q  <= (state_nxt == SPR_OWN);
    end
  end

  // Next-state and combinational grants; grants are forced low during reset.
  always_comb begin
    state_nxt   = state;
    bg_grant_c  = 1'b0;
    spr_grant_c = 1'b0;
    case (state)
      BG_OWN: begin
        bg_grant_c = bus.bg_req_in;
        if (bus.spr_claim_in) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!bus.spr_claim_in)      state_nxt = BG_OWN;
        else if (inflight == '0)    state_nxt = SPR_OWN;
      end
      SPR_OWN: begin
        spr_grant_c = bus.spr_claim_in && bus.spr_req_in;
        if (!bus.spr_claim_in && inflight == '0) state_nxt = BG_OWN;
      end
      default: state_nxt = BG_OWN;
    endcase
    if (rst_in) begin
      bg_grant_c  = 1'b0;
      spr_grant_c = 1'b0;
    end
  end

  // Issue stage: registered VRAM address/enable and owner tag (1 = sprite).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      re_q   <= 1'b0;
      tag_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      re_q  <= bg_grant_c | spr_grant_c;
      tag_q <= spr_grant_c;
      if (spr_grant_c)     addr_q <= bus.spr_addr_in;
      else if (bg_grant_c) addr_q <= bus.bg_addr_in;
    end
  end

  // Tag/valid shift register tracking reads through the BRAM latency.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot_vld <= '0;
      slot_tag <= '0;
    end else begin
      slot_vld[0] <= re_q;
      slot_tag[0] <= tag_q;
      for (int i = 1; i < int'(LATENCY); i++) begin
        slot_vld[i] <= slot_vld[i-1];
        slot_tag[i] <= slot_tag[i-1];
      end
    end
  end

  // Capture returning data into the owner's output as its slot exits.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bg_vld_q   <= 1'b0;
      spr_vld_q  <= 1'b0;
      bg_data_q  <= '0;
      spr_data_q <= '0;
    end else begin
      bg_vld_q  <= slot_vld[LATENCY-1] && !slot_tag[LATENCY-1];
      spr_vld_q <= slot_vld[LATENCY-1] &&  slot_tag[LATENCY-1];
      if (slot_vld[LATENCY-1] && !slot_tag[LATENCY-1]) bg_data_q  <= bus.vram_data_in;
      if (slot_vld[LATENCY-1] &&  slot_tag[LATENCY-1]) spr_data_q <= bus.vram_data_in;
    end
  end

`ifdef FETCH_ARB_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles where BG asks but is not granted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_q <= '0;
    end else if (bus.stats_clr_in) begin
      stall_q <= '0;
    end else if (bus.bg_req_in && !bg_grant_c && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.bg_stall_cycles_out = stall_q;
`endif

  assign bus.bg_grant_out       = bg_grant_c;
  assign bus.spr_grant_out      = spr_grant_c;
  assign bus.bg_pause_out       = pause_q;
  assign bus.mem_free_out       = free_q;
  assign bus.vram_re_out        = re_q;
  assign bus.vram_addr_out      = addr_q;
  assign bus.bg_data_valid_out  = bg_vld_q;
  assign bus.bg_data_out        = bg_data_q;
  assign bus.spr_data_valid_out = spr_vld_q;
  assign bus.spr_data_out       = spr_data_q;
endmodule
